stream_source: RTL and testbench

STREAM_SOURCE -- requirements
Module: stream_source

---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_source.sv | 124 ++++++++++++
 tb/tb_stream_source.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and default sizing for the stream source burst generator.
package stream_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_GAP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_FIN
   } state_t;

endpackage

// File: rtl/stream_source.sv
// Burst generator: emits count beats of an arithmetic sequence over a valid/ready
// stream, with an optional idle gap after each accepted beat. All outputs are flops.
module stream_source
   import stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W,
   parameter int GAP_W = DEF_GAP_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_first,
   input  logic [WIDTH-1:0] i_step,
   input  logic [CNT_W-1:0] i_count,
   input  logic [GAP_W-1:0] i_gap,
   output logic [WIDTH-1:0] o_data,
   output logic             o_vld,
   input  logic             i_rdy,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_beats
);

   state_t           state, state_n;
   logic [WIDTH-1:0] step_q, step_n;
   logic [CNT_W-1:0] count_q, count_n;
   logic [GAP_W-1:0] gap_q, gap_n;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
   logic [WIDTH-1:0] data_n;
   logic [CNT_W-1:0] beats_n, beats_inc;
   logic             vld_n, done_n, busy_n;

   assign beats_inc = o_beats + CNT_W'(1);

   always_comb begin
      state_n   = state;
      step_n    = step_q;
      count_n   = count_q;
      gap_n     = gap_q;
      gap_cnt_n = gap_cnt;
      data_n    = o_data;
      beats_n   = o_beats;
      vld_n     = o_vld;
      done_n    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               step_n  = i_step;
               count_n = i_count;
               gap_n   = i_gap;
               data_n  = i_first;
               beats_n = '0;
               if (i_count != '0) begin
                  state_n = ST_SEND;
                  vld_n   = 1'b1;
               end else begin
                  state_n = ST_FIN;
                  done_n  = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (o_vld && i_rdy) begin
               beats_n = beats_inc;
               data_n  = o_data + step_q;
               if (beats_inc == count_q) begin
                  state_n = ST_FIN;
                  vld_n   = 1'b0;
                  done_n  = 1'b1;
               end else if (gap_q != '0) begin
                  state_n   = ST_GAP;
                  gap_cnt_n = gap_q;
                  vld_n     = 1'b0;
               end
            end
         end
         ST_GAP: begin
            // gap_cnt is loaded with a nonzero gap, so the last idle cycle is at 1
            if (gap_cnt == GAP_W'(1)) begin
               state_n = ST_SEND;
               vld_n   = 1'b1;
            end else begin
               gap_cnt_n = gap_cnt - GAP_W'(1);
            end
         end
         ST_FIN: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            vld_n   = 1'b0;
         end
      endcase
      busy_n = (state_n != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         step_q  <= '0;
         count_q <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         o_data  <= '0;
         o_beats <= '0;
         o_vld   <= 1'b0;
         o_done  <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         state   <= state_n;
         step_q  <= step_n;
         count_q <= count_n;
         gap_q   <= gap_n;
         gap_cnt <= gap_cnt_n;
         o_data  <= data_n;
         o_beats <= beats_n;
         o_vld   <= vld_n;
         o_done  <= done_n;
         o_busy  <= busy_n;
      end
   end

endmodule

// File: tb/tb_stream_source.sv
// Scoreboard bench for stream_source: expected beats queued at start, popped on handshake.
module tb_stream_source;
   import stream_pkg::*;

   localparam int WIDTH = DEF_WIDTH;
   localparam int CNT_W = DEF_CNT_W;
   localparam int GAP_W = DEF_GAP_W;

   logic             i_clk = 1'b0;
   logic             i_reset = 1'b1;
   logic             i_start = 1'b0;
   logic [WIDTH-1:0] i_first = '0;
   logic [WIDTH-1:0] i_step = '0;
   logic [CNT_W-1:0] i_count = '0;
   logic [GAP_W-1:0] i_gap = '0;
   logic             i_rdy = 1'b1;
   logic [WIDTH-1:0] o_data;
   logic             o_vld;
   logic             o_busy;
   logic             o_done;
   logic [CNT_W-1:0] o_beats;

   stream_source #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_first(i_first),
      .i_step(i_step), .i_count(i_count), .i_gap(i_gap), .o_data(o_data),
      .o_vld(o_vld), .i_rdy(i_rdy), .o_busy(o_busy), .o_done(o_done),
      .o_beats(o_beats)
   );

   always #5 i_clk = ~i_clk;

   int total = 0, bad = 0;
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   logic [WIDTH-1:0] exp_q[$];
   int spacing = 0, hs_cnt = 0, last_hs = 0, first_hs = 0;
   int done_cnt = 0, done_cyc = 0, start_cyc = 0;

   // Monitor: a handshake is o_vld & i_rdy seen just before the next rising edge
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_vld && i_rdy) begin
            chk("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("data", o_data, exp_q.pop_front());
            if (spacing > 0 && hs_cnt > 0) chk("spacing", cyc - last_hs, spacing);
            if (hs_cnt == 0) first_hs = cyc;
            hs_cnt++;
            last_hs = cyc;
         end
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge i_clk);
      #1;
   endtask

   task automatic start_burst(input logic [WIDTH-1:0] first, input logic [WIDTH-1:0] step,
                              input logic [CNT_W-1:0] count, input logic [GAP_W-1:0] gap);
      logic [WIDTH-1:0] d;
      d = first;
      for (int k = 0; k < int'(count); k++) begin
         exp_q.push_back(d);
         d = d + step;
      end
      hs_cnt    = 0;
      i_first   = first;
      i_step    = step;
      i_count   = count;
      i_gap     = gap;
      i_start   = 1'b1;
      start_cyc = cyc;
      tick();
      i_start = 1'b0;
      i_first = WIDTH'($urandom);
      i_step  = WIDTH'($urandom);
      i_count = CNT_W'($urandom);
      i_gap   = GAP_W'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int d0, n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         sample();
         n++;
      end
      chk("done_timeout", n < budget, 1);
   endtask

   initial begin
      // reset, with a start request competing against it
      i_start = 1'b1;
      i_count = 3;
      repeat (2) tick();
      sample();
      chk("rst_vld", o_vld, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_data", o_data, 0);
      chk("rst_beats", o_beats, 0);
      tick();
      i_start = 1'b0;
      i_reset = 1'b0;
      tick();

      // basic burst, back to back
      spacing = 1;
      start_burst(8'h10, 8'h01, 4, 0);
      wait_done(20);
      chk("basic_first_lat", first_hs, start_cyc + 1);
      chk("basic_done_cyc", done_cyc, last_hs + 1);
      chk("basic_beats", o_beats, 4);
      chk("basic_busy_fin", o_busy, 1);
      chk("basic_sb_empty", exp_q.size(), 0);
      tick();
      sample();
      chk("basic_busy_idle", o_busy, 0);
      chk("basic_done_pulse", o_done, 0);
      tick();

      // backpressure while 8'h11 is presented
      spacing = 0;
      start_burst(8'h10, 8'h01, 4, 0);
      tick();
      i_rdy = 1'b0;
      repeat (3) begin
         sample();
         chk("bp_vld", o_vld, 1);
         chk("bp_data", o_data, 8'h11);
         tick();
      end
      i_rdy = 1'b1;
      wait_done(20);
      chk("bp_beats", o_beats, 4);
      chk("bp_sb_empty", exp_q.size(), 0);
      tick();

      // wrap through zero with a 2-cycle gap
      spacing = 3;
      start_burst(8'hFE, 8'h01, 3, 2);
      wait_done(30);
      chk("wrap_beats", o_beats, 3);
      chk("wrap_sb_empty", exp_q.size(), 0);
      tick();

      // zero count; start held through FIN (ignored) and the next IDLE (accepted)
      spacing = 0;
      i_first = 8'h55;
      i_step  = 8'h01;
      i_count = 0;
      i_gap   = 0;
      i_start = 1'b1;
      tick();
      sample();
      chk("zero_done", o_done, 1);
      chk("zero_vld", o_vld, 0);
      chk("zero_beats", o_beats, 0);
      tick();
      sample();
      chk("fin_start_ignored", o_done, 0);
      chk("fin_idle_busy", o_busy, 0);
      tick();
      i_start = 1'b0;
      sample();
      chk("idle_start_taken", o_done, 1);
      tick();
      tick();

      // start pulsed mid-burst must not disturb the running burst
      spacing = 2;
      start_burst(8'h00, 8'h03, 5, 1);
      repeat (3) tick();
      i_first = 8'h80;
      i_count = 5;
      i_gap   = 0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      wait_done(40);
      chk("busy_start_beats", o_beats, 5);
      repeat (5) begin
         tick();
         sample();
         chk("busy_start_quiet", o_busy, 0);
      end
      chk("busy_start_sb_empty", exp_q.size(), 0);
      tick();

      // reset after two of six beats
      spacing = 1;
      start_burst(8'h40, 8'h01, 6, 0);
      begin
         int n;
         n = 0;
         while (hs_cnt < 2 && n < 20) begin
            sample();
            n++;
         end
         chk("mid_wait_timeout", n < 20, 1);
      end
      tick();
      i_reset = 1'b1;
      tick();
      sample();
      chk("mid_rst_vld", o_vld, 0);
      chk("mid_rst_beats", o_beats, 0);
      chk("mid_rst_busy", o_busy, 0);
      begin
         int d0;
         d0 = done_cnt;
         tick();
         i_reset = 1'b0;
         exp_q.delete();
         repeat (4) begin
            sample();
            tick();
         end
         chk("mid_rst_no_done", done_cnt, d0);
      end
      start_burst(8'h05, 8'h02, 3, 0);
      wait_done(20);
      chk("post_rst_beats", o_beats, 3);
      chk("post_rst_sb_empty", exp_q.size(), 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
